muldiv_sequencer: RTL
=====================

Name: muldiv_sequencer

Overview:
- Iterative RV32M multiply/divide unit that sits beside the main ALU in the execute stage.
- Accepts one operation at a time and runs a one-bit-per-cycle shift-add multiply or restoring divide over DATA_WIDTH cycles.
- Returns a registered result with a single-cycle Done pulse.
- The hazard unit uses Busy to stall the pipeline while an operation is in flight.

Parameters:
- DATA_WIDTH, 32, operand and result width; must be even and at least 8.

Ports:
- clk  input  1  system clock, rising edge
- rst  input  1  asynchronous reset, active-high
- Start  input  1  request; sampled only when Ready=1
- Op  input  3  funct3 encoding: 000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU
- SrcA  input  DATA_WIDTH  rs1 operand (multiplicand / dividend)
- SrcB  input  DATA_WIDTH  rs2 operand (multiplier / divisor)
- Flush  input  1  abort the current operation (branch mispredict or trap)
- Ready  output  1  unit idle, Start will be accepted
- Busy  output  1  operation in flight; equals ~Ready
- Done  output  1  one-cycle pulse, Result valid
- Result  output  DATA_WIDTH  result of the last completed operation

Behaviour:
- Clock and reset: one clock domain (clk). Reset is asynchronous and active-high (rst).
- Reset values: state IDLE, Ready=1, Busy=0, Done=0, Result=0, all internal registers 0.
- Reset mid-operation: immediate return to IDLE with reset values; no Done is issued.
- State IDLE:
  - Ready=1.
  - Start=1 and Flush=0 at a rising edge: latch Op, SrcA and SrcB; compute the sign flags; take absolute values per Op; go to CALC with counter=DATA_WIDTH-1.
- State CALC:
  - Busy=1. One iteration per cycle; the counter decrements.
  - After the counter=0 iteration: go to FIX.
  - Start is ignored in CALC.
- State FIX (1 cycle):
  - Apply sign correction by two's-complement negate, select the result half, register Result.
  - Go to DONE.
- State DONE (1 cycle):
  - Done=1, Busy=1.
  - Next state is IDLE.
- Latency: Start accepted at edge t gives Done high during cycle t+DATA_WIDTH+2. There is no back-to-back overlap.
- Result holds its value until the next completed operation.
- Flush:
  - Asserted in CALC, FIX or DONE: go to IDLE at the next edge. Done is suppressed and Result is unchanged.
  - Flush with Start in the same cycle: Flush wins and Start is not accepted.
- Multiply:
  - 2*DATA_WIDTH-bit unsigned product from the magnitudes.
  - Negate if the signs differ (MULH: both operands signed; MULHSU: SrcA signed only; MUL and MULHU: unsigned path).
  - MUL returns the low half. MULH, MULHSU and MULHU return the high half.
- Divide:
  - Restoring divide on the magnitudes. DIV and REM use the signed path; DIVU and REMU use the unsigned path.
  - Quotient is negated if the signs differ. Remainder takes the sign of the dividend.
- Divide by zero:
  - Quotient = all ones.
  - Remainder = SrcA.
  - Done is still raised (no trap).
- Signed overflow (DIV/REM with SrcA = most-negative, SrcB = -1):
  - Quotient = SrcA.
  - Remainder = 0.

Optional Feature:
- Macro: MULDIV_EARLY_OUT_EN.
- When defined:
  - Divide-by-zero, signed overflow, and any multiply with a zero operand skip CALC and FIX.
  - IDLE goes directly to DONE, so Done is high during cycle t+1.
  - Result is identical to the iterative path.
- When undefined: every operation takes the full DATA_WIDTH+2 latency. Using this fixed latency is the baseline for timing-deterministic builds.

Test Plan:
- MUL, SrcA=7, SrcB=0xFFFFFFFD -> Done at t+34, Result=0xFFFFFFEB, Busy high for 34 cycles.
- MULH 0x80000000 x 0x80000000 -> 0x40000000.
- MULHU 0xFFFFFFFF x 0xFFFFFFFF -> 0xFFFFFFFE.
- MULHSU 0xFFFFFFFF x 0x00000002 -> 0xFFFFFFFF.
- DIV 0xFFFFFFF9 / 2 -> 0xFFFFFFFD. REM with the same operands -> 0xFFFFFFFF. DIVU 0xFFFFFFF9 / 2 -> 0x7FFFFFFC.
- Divide by zero: DIVU 5/0 -> 0xFFFFFFFF. REM 5/0 -> 5.
- Signed overflow: DIV 0x80000000 / 0xFFFFFFFF -> 0x80000000. REM with the same operands -> 0.
- With MULDIV_EARLY_OUT_EN defined: the divide-by-zero and overflow cases above give Done at t+1.
- Flush in cycle 10 of CALC -> no Done, Ready=1 next cycle, Result unchanged.
- Start held high during CALC -> ignored: exactly one Done per accepted Start.
- Flush+Start together in IDLE -> not accepted.
- Assert rst mid-CALC -> outputs go to reset values asynchronously, before the next clock edge.
- After rst deasserts, a new MUL 3x4 -> 12.

Source files
------------

// File: rtl/muldiv_sequencer.sv
// rtl/muldiv_sequencer.sv - iterative RV32M multiply/divide sequencer
//
// One operation at a time: shift-add multiply or restoring divide, one bit
// per cycle over DATA_WIDTH cycles, then a sign-fix cycle and a Done cycle.
//
// Parameters:
//   DATA_WIDTH  operand/result width (even, >= 8)
// Ports:
//   clk, rst    clock (rising edge), asynchronous active-high reset
//   Start       request, sampled only while Ready
//   Op          funct3: MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU
//   SrcA, SrcB  rs1 / rs2 operands
//   Flush       abort the operation in flight; also blocks a same-cycle Start
//   Ready/Busy  idle / operation in flight (Busy = ~Ready)
//   Done        one-cycle pulse, Result valid
//   Result      result of the last completed operation
// Optional feature:
//   MULDIV_EARLY_OUT_EN  divide-by-zero, signed overflow and multiplies with
//                        a zero operand go straight from IDLE to DONE.

module muldiv_sequencer #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  Start,
    input  logic [2:0]            Op,
    input  logic [DATA_WIDTH-1:0] SrcA,
    input  logic [DATA_WIDTH-1:0] SrcB,
    input  logic                  Flush,
    output logic                  Ready,
    output logic                  Busy,
    output logic                  Done,
    output logic [DATA_WIDTH-1:0] Result
);

    localparam int W  = DATA_WIDTH;
    localparam int CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2,
        DONE = 2'd3
    } state_t;

    state_t        state;
    state_t        state_next;

    logic [2:0]    op_q;
    logic          neg_q;      // negate the selected result in FIX
    logic [CW-1:0] count;
    logic [W-1:0]  acc;        // multiply: product high half; divide: remainder
    logic [W-1:0]  quo;        // multiply: multiplier/product low; divide: dividend/quotient
    logic [W-1:0]  opb;        // multiply: multiplicand magnitude; divide: divisor magnitude
    logic [W-1:0]  pending;    // result of the operation currently in DONE
    logic [W-1:0]  committed;  // result of the last operation that completed

    // ------------------------------------------------------------------
    // Operand decode at acceptance
    // ------------------------------------------------------------------
    logic         accept;
    logic         signed_a;
    logic         signed_b;
    logic         sign_a;
    logic         sign_b;
    logic         b_zero;
    logic         neg_in;
    logic [W-1:0] mag_a;
    logic [W-1:0] mag_b;
    logic         early_in;
    logic [W-1:0] early_res;

    always_comb begin
        // SrcA is signed for MULH, MULHSU, DIV, REM; SrcB for MULH, DIV, REM
        signed_a = Op[2] ? ~Op[0] : ((Op[1:0] == 2'b01) || (Op[1:0] == 2'b10));
        signed_b = Op[2] ? ~Op[0] : (Op[1:0] == 2'b01);
        sign_a   = signed_a & SrcA[W-1];
        sign_b   = signed_b & SrcB[W-1];
        mag_a    = sign_a ? (~SrcA + 1'b1) : SrcA;
        mag_b    = sign_b ? (~SrcB + 1'b1) : SrcB;
        b_zero   = (SrcB == '0);
        if (!Op[2]) begin
            neg_in = sign_a ^ sign_b;
        end else if (Op[1]) begin
            neg_in = sign_a;                       // remainder follows the dividend
        end else begin
            neg_in = (sign_a ^ sign_b) & ~b_zero;  // divide-by-zero quotient stays all ones
        end
    end

`ifdef MULDIV_EARLY_OUT_EN
    logic ovf_in;

    always_comb begin
        ovf_in    = Op[2] && !Op[0] && (SrcA == {1'b1, {(W-1){1'b0}}}) && (SrcB == '1);
        early_in  = Op[2] ? (b_zero || ovf_in) : ((SrcA == '0) || b_zero);
        early_res = '0;
        if (Op[2]) begin
            if (b_zero) begin
                early_res = Op[1] ? SrcA : '1;
            end else begin
                early_res = Op[1] ? '0 : SrcA;
            end
        end
    end
`else
    always_comb begin
        early_in  = 1'b0;
        early_res = '0;
    end
`endif

    assign accept = (state == IDLE) && Start && !Flush;

    // ------------------------------------------------------------------
    // One iteration of the multiply / divide step
    // ------------------------------------------------------------------
    logic [W:0]   mul_sum;
    logic [W:0]   shifted;
    logic         ge;
    logic [W-1:0] sub;
    logic [W-1:0] acc_nxt;
    logic [W-1:0] quo_nxt;

    always_comb begin
        mul_sum = {1'b0, acc} + (quo[0] ? {1'b0, opb} : {(W+1){1'b0}});
        shifted = {acc, quo[W-1]};
        ge      = (shifted >= {1'b0, opb});
        // When ge holds the true difference is below opb, so W bits suffice
        sub     = shifted[W-1:0] - opb;
        if (op_q[2]) begin
            acc_nxt = ge ? sub : shifted[W-1:0];
            quo_nxt = {quo[W-2:0], ge};
        end else begin
            acc_nxt = mul_sum[W:1];
            quo_nxt = {mul_sum[0], quo[W-1:1]};
        end
    end

    // ------------------------------------------------------------------
    // Sign correction and result selection
    // ------------------------------------------------------------------
    logic [2*W-1:0] prod;
    logic [2*W-1:0] prod_s;
    logic [W-1:0]   div_raw;
    logic [W-1:0]   fix_res;

    always_comb begin
        prod    = {acc, quo};
        prod_s  = neg_q ? (~prod + 1'b1) : prod;
        div_raw = op_q[1] ? acc : quo;
        if (op_q[2]) begin
            fix_res = neg_q ? (~div_raw + 1'b1) : div_raw;
        end else if (op_q[1:0] == 2'b00) begin
            fix_res = prod_s[W-1:0];
        end else begin
            fix_res = prod_s[2*W-1:W];
        end
    end

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        Ready      = (state == IDLE);
        Busy       = (state != IDLE);
        // A flush landing in DONE withdraws the pulse and the result with it
        Done       = (state == DONE) && !Flush;
        Result     = Done ? pending : committed;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_next = early_in ? DONE : CALC;
                end
            end
            CALC: begin
                if (count == CW'(0)) begin
                    state_next = FIX;
                end
            end
            FIX:     state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (Flush && (state != IDLE)) begin
            state_next = IDLE;
        end
    end

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            op_q      <= '0;
            neg_q     <= 1'b0;
            count     <= '0;
            acc       <= '0;
            quo       <= '0;
            opb       <= '0;
            pending   <= '0;
            committed <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        op_q    <= Op;
                        neg_q   <= neg_in;
                        count   <= CW'(W - 1);
                        acc     <= '0;
                        quo     <= Op[2] ? mag_a : mag_b;
                        opb     <= Op[2] ? mag_b : mag_a;
                        pending <= early_res;
                    end
                end
                CALC: begin
                    acc   <= acc_nxt;
                    quo   <= quo_nxt;
                    count <= count - 1'b1;
                end
                FIX: begin
                    if (!Flush) begin
                        pending <= fix_res;
                    end
                end
                DONE: begin
                    if (!Flush) begin
                        committed <= pending;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
